// File: rtl/whack_judge_if.sv
// whack_judge_if
//   Bundles the signals exchanged between the Whac-A-Mole game logic and the
//   hit/miss judge. The clock and reset stay outside this bundle.
//
//   Signals:
//     en          round running; a rising edge starts a new round
//     btn         debounced buttons, 1 = pressed
//     mole        currently lit mole, one-hot or all-zero
//     hit_pulse   one-cycle pulse per hit
//     miss_pulse  one-cycle pulse per miss
//     mole_clear  one-cycle request to retire the hit mole
//     score_bcd   score, [7:4] tens, [3:0] units
//     miss_cnt    misses this round, binary
//     game_over   high while the round is over
//
//   Modports:
//     master  game side: drives en/btn/mole, observes the judge's results
//     slave   the judge itself
interface whack_judge_if #(
  parameter int NBTN = 8
);
  logic            en;
  logic [NBTN-1:0] btn;
  logic [NBTN-1:0] mole;
  logic            hit_pulse;
  logic            miss_pulse;
  logic            mole_clear;
  logic [7:0]      score_bcd;
  logic [3:0]      miss_cnt;
  logic            game_over;

  modport master (
    output en, btn, mole,
    input  hit_pulse, miss_pulse, mole_clear, score_bcd, miss_cnt, game_over
  );

  modport slave (
    input  en, btn, mole,
    output hit_pulse, miss_pulse, mole_clear, score_bcd, miss_cnt, game_over
  );
endinterface

// File: rtl/whack_judge.sv
// whack_judge
//   Hit/miss judge for the Whac-A-Mole game. Detects new button presses,
//   classifies each press cycle as a hit or a miss against the lit mole,
//   keeps a saturating two-digit BCD score and a miss counter, and flags
//   game over once the miss limit is reached. All outputs are registered.
//
//   Ports:
//     clk  system clock, everything changes on the rising edge
//     rst  synchronous, active-low reset
//     bus  whack_judge_if slave modport (en/btn/mole in, results out)
module whack_judge #(
  parameter int NBTN       = 8,
  parameter int MISS_LIMIT = 9
) (
  input  logic         clk,
  input  logic         rst,
  whack_judge_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    LOCK  = 2'd2,
    OVER  = 2'd3
  } state_t;

  localparam logic [3:0] MISS_LIMIT_C = 4'(MISS_LIMIT);

  state_t          state_q, state_d;
  logic [NBTN-1:0] btn_prev_q;
  logic [NBTN-1:0] locked_mole_q, locked_mole_d;
  logic [7:0]      score_q, score_d;
  logic [3:0]      miss_cnt_q, miss_cnt_d;
  logic            hit_q, hit_d;
  logic            miss_q, miss_d;
  logic            clear_q, clear_d;
  logic            over_q, over_d;

  logic [NBTN-1:0] press;
  logic [3:0]      miss_inc;

  assign press    = bus.btn & ~btn_prev_q;
  assign miss_inc = miss_cnt_q + 4'd1;

  // BCD increment that sticks at 99 so the score never wraps.
  function automatic logic [7:0] bcd_inc(input logic [7:0] s);
    logic [7:0] r;
    if (s == 8'h99)
      r = s;
    else if (s[3:0] == 4'd9)
      r = {s[7:4] + 4'd1, 4'd0};
    else
      r = {s[7:4], s[3:0] + 4'd1};
    return r;
  endfunction

  // Next-state and registered-output logic. Dropping en wins over
  // everything, so a press in the same cycle is discarded.
  always_comb begin
    state_d       = state_q;
    locked_mole_d = locked_mole_q;
    score_d       = score_q;
    miss_cnt_d    = miss_cnt_q;
    hit_d         = 1'b0;
    miss_d        = 1'b0;
    clear_d       = 1'b0;

    if (!bus.en) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          // A press coinciding with the round start is deliberately not judged.
          state_d    = ARMED;
          score_d    = 8'h00;
          miss_cnt_d = 4'd0;
        end
        ARMED: begin
          if (press != '0) begin
            // Simultaneous presses form one event; any match makes it a hit.
            if ((press & bus.mole) != '0) begin
              hit_d         = 1'b1;
              clear_d       = 1'b1;
              score_d       = bcd_inc(score_q);
              locked_mole_d = bus.mole;
              state_d       = LOCK;
            end else begin
              miss_d     = 1'b1;
              miss_cnt_d = miss_inc;
              if (miss_inc == MISS_LIMIT_C)
                state_d = OVER;
            end
          end
        end
        LOCK: begin
          // Wait for the generator to retire the mole (or blank it) before
          // judging again, so one mole can only be scored once.
          if (bus.mole != locked_mole_q)
            state_d = ARMED;
        end
        OVER: begin
          state_d = OVER;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    over_d = (state_d == OVER);
  end

  // State and output registers. btn_prev resets to all-ones so a button held
  // through reset does not look like a fresh press.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= IDLE;
      btn_prev_q    <= '1;
      locked_mole_q <= '0;
      score_q       <= 8'h00;
      miss_cnt_q    <= 4'd0;
      hit_q         <= 1'b0;
      miss_q        <= 1'b0;
      clear_q       <= 1'b0;
      over_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      btn_prev_q    <= bus.btn;
      locked_mole_q <= locked_mole_d;
      score_q       <= score_d;
      miss_cnt_q    <= miss_cnt_d;
      hit_q         <= hit_d;
      miss_q        <= miss_d;
      clear_q       <= clear_d;
      over_q        <= over_d;
    end
  end

  assign bus.hit_pulse  = hit_q;
  assign bus.miss_pulse = miss_q;
  assign bus.mole_clear = clear_q;
  assign bus.score_bcd  = score_q;
  assign bus.miss_cnt   = miss_cnt_q;
  assign bus.game_over  = over_q;

endmodule

// File: tb/tb_whack_judge.sv
// tb_whack_judge
//   Directed bench for whack_judge. A behavioural model of the game rules
//   (integer score, integer miss count, round flags) predicts every output;
//   the DUT is compared to it each cycle, and literal expectations pin the
//   model at the interesting points of each scenario.
module tb_whack_judge;

  localparam int NBTN  = 8;
  localparam int LIMIT = 9;

  logic clk = 1'b0;
  logic rst;

  whack_judge_if #(.NBTN(NBTN)) bus ();

  whack_judge #(.NBTN(NBTN), .MISS_LIMIT(LIMIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checksTotal  = 0;
  int checksPassed = 0;
  int hitCount     = 0;
  int missCount    = 0;
  int clearCount   = 0;

  // Behavioural model state, updated only by the model process.
  bit        modelValid = 0;
  logic [7:0] mPrev     = '1;
  bit        mRunning   = 0;
  bit        mWaiting   = 0;
  bit        mFinished  = 0;
  logic [7:0] mLocked   = '0;
  int        mScore     = 0;
  int        mMiss      = 0;
  bit        eHit       = 0;
  bit        eMiss      = 0;
  bit        eClear     = 0;

  // Model of the game rules, evaluated on every rising edge with the
  // inputs that were stable before it.
  initial begin
    logic [7:0] press;
    forever begin
      @(posedge clk);
      press  = bus.btn & ~mPrev;
      mPrev  = bus.btn;
      eHit   = 0;
      eMiss  = 0;
      eClear = 0;
      if (!rst) begin
        modelValid = 1;
        mPrev      = '1;
        mRunning   = 0;
        mWaiting   = 0;
        mFinished  = 0;
        mLocked    = '0;
        mScore     = 0;
        mMiss      = 0;
      end else if (!bus.en) begin
        mRunning  = 0;
        mWaiting  = 0;
        mFinished = 0;
      end else if (!mRunning) begin
        mRunning = 1;
        mScore   = 0;
        mMiss    = 0;
      end else if (mFinished) begin
        mFinished = 1;
      end else if (mWaiting) begin
        if (bus.mole != mLocked) mWaiting = 0;
      end else if (press != 0) begin
        if ((press & bus.mole) != 0) begin
          eHit     = 1;
          eClear   = 1;
          mScore   = (mScore >= 99) ? 99 : mScore + 1;
          mWaiting = 1;
          mLocked  = bus.mole;
        end else begin
          eMiss = 1;
          mMiss = mMiss + 1;
          if (mMiss == LIMIT) mFinished = 1;
        end
      end
    end
  end

  function automatic logic [7:0] toBcd(input int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checksTotal++;
    if (act === exp) checksPassed++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Per-cycle comparison of every DUT output against the model.
  task automatic compareCycle();
    if (modelValid) begin
      checkVal("hit_pulse",  32'(bus.hit_pulse),  32'(eHit));
      checkVal("miss_pulse", 32'(bus.miss_pulse), 32'(eMiss));
      checkVal("mole_clear", 32'(bus.mole_clear), 32'(eClear));
      checkVal("score_bcd",  32'(bus.score_bcd),  32'(toBcd(mScore)));
      checkVal("miss_cnt",   32'(bus.miss_cnt),   32'(mMiss));
      checkVal("game_over",  32'(bus.game_over),  32'(mFinished));
    end
    if (bus.hit_pulse === 1'b1)  hitCount++;
    if (bus.miss_pulse === 1'b1) missCount++;
    if (bus.mole_clear === 1'b1) clearCount++;
  endtask

  // Drive inputs, then run n clock cycles comparing at each falling edge.
  task automatic applyStimulus(input logic r, input logic e, input logic [7:0] b,
                               input logic [7:0] m, input int n);
    rst      = r;
    bus.en   = e;
    bus.btn  = b;
    bus.mole = m;
    repeat (n) begin
      @(negedge clk);
      compareCycle();
    end
  endtask

  // Literal (hand-computed) expectations on the current outputs.
  task automatic checkOutput(input string tag, input logic [7:0] score, input logic [3:0] misses,
                             input logic over);
    checkVal({tag, " score"},     32'(bus.score_bcd), 32'(score));
    checkVal({tag, " miss_cnt"},  32'(bus.miss_cnt),  32'(misses));
    checkVal({tag, " game_over"}, 32'(bus.game_over), 32'(over));
  endtask

  initial begin
    int baseHit;
    int baseMiss;
    logic [7:0] m;

    // Reset with a button held, then start a round: nothing may fire.
    applyStimulus(1'b0, 1'b0, 8'h01, 8'h00, 2);
    checkOutput("reset", 8'h00, 4'd0, 1'b0);
    checkVal("reset hit_pulse", 32'(bus.hit_pulse), 32'd0);
    applyStimulus(1'b1, 1'b1, 8'h01, 8'h00, 2);
    checkOutput("start", 8'h00, 4'd0, 1'b0);
    checkVal("held-through-reset pulses", 32'(hitCount + missCount), 32'd0);

    // Held press on the lit mole: exactly one hit, then locked.
    applyStimulus(1'b1, 1'b1, 8'h00, 8'h04, 1);
    applyStimulus(1'b1, 1'b1, 8'h04, 8'h04, 5);
    checkVal("held press hits", 32'(hitCount), 32'd1);
    checkVal("held press clears", 32'(clearCount), 32'd1);
    checkOutput("first hit", 8'h01, 4'd0, 1'b0);
    applyStimulus(1'b1, 1'b1, 8'h00, 8'h04, 1);
    applyStimulus(1'b1, 1'b1, 8'h04, 8'h04, 1);
    checkVal("press in lock", 32'(hitCount + missCount), 32'd1);
    applyStimulus(1'b1, 1'b1, 8'h00, 8'h10, 1);

    // Two buttons at once, one on the mole: single hit, no miss.
    applyStimulus(1'b1, 1'b1, 8'h00, 8'h04, 1);
    applyStimulus(1'b1, 1'b1, 8'h24, 8'h04, 1);
    applyStimulus(1'b1, 1'b1, 8'h00, 8'h10, 1);
    checkOutput("dual press", 8'h02, 4'd0, 1'b0);
    checkVal("dual press hits", 32'(hitCount), 32'd2);

    // Nine misses end the round; a tenth press is ignored.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 1'b1, 8'h01, 8'h10, 1);
      applyStimulus(1'b1, 1'b1, 8'h00, 8'h10, 1);
      if (i == 8) checkOutput("ninth miss", 8'h02, 4'd9, 1'b1);
    end
    checkVal("miss pulses", 32'(missCount), 32'd9);
    checkOutput("after tenth", 8'h02, 4'd9, 1'b1);
    applyStimulus(1'b1, 1'b0, 8'h00, 8'h10, 1);
    applyStimulus(1'b1, 1'b1, 8'h00, 8'h10, 1);
    checkOutput("restart", 8'h00, 4'd0, 1'b0);

    // 105 hits with the mole alternating: BCD carry and saturation at 99.
    baseHit = hitCount;
    for (int i = 1; i <= 105; i++) begin
      m = (i % 2 == 1) ? 8'h01 : 8'h02;
      applyStimulus(1'b1, 1'b1, 8'h00, m, 1);
      applyStimulus(1'b1, 1'b1, m, m, 1);
      if (i == 9)   checkOutput("score 9", 8'h09, 4'd0, 1'b0);
      if (i == 10)  checkOutput("score 10", 8'h10, 4'd0, 1'b0);
      if (i == 99)  checkOutput("score 99", 8'h99, 4'd0, 1'b0);
      if (i == 105) checkOutput("saturated", 8'h99, 4'd0, 1'b0);
    end
    checkVal("hits at saturation", 32'(hitCount - baseHit), 32'd105);

    // Press on the edge where en falls: no pulse, counts frozen.
    applyStimulus(1'b1, 1'b1, 8'h00, 8'h08, 1);
    baseHit  = hitCount;
    baseMiss = missCount;
    applyStimulus(1'b1, 1'b0, 8'h08, 8'h08, 1);
    checkVal("en-fall press", 32'((hitCount - baseHit) + (missCount - baseMiss)), 32'd0);
    checkOutput("en-fall", 8'h99, 4'd0, 1'b0);

    // en rising with a press: counts clear, that press is not judged.
    applyStimulus(1'b1, 1'b1, 8'h08, 8'h08, 1);
    applyStimulus(1'b1, 1'b1, 8'h08, 8'h08, 1);
    checkVal("en-rise press", 32'(hitCount - baseHit), 32'd0);
    checkOutput("en-rise", 8'h00, 4'd0, 1'b0);

    // Hit, then reset while locked: everything returns to reset values.
    applyStimulus(1'b1, 1'b1, 8'h00, 8'h08, 1);
    applyStimulus(1'b1, 1'b1, 8'h08, 8'h08, 1);
    checkOutput("pre-reset", 8'h01, 4'd0, 1'b0);
    applyStimulus(1'b0, 1'b1, 8'h00, 8'h10, 1);
    checkOutput("mid-lock reset", 8'h00, 4'd0, 1'b0);
    checkVal("reset hit_pulse", 32'(bus.hit_pulse), 32'd0);
    applyStimulus(1'b1, 1'b0, 8'h00, 8'h00, 2);

    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule
